// File: rtl/ysyx_23060236_axi_pkg.sv
// Shared definitions for the ysyx_23060236 AXI arbiter: FSM states, AXI burst and
// response encodings, and a one-hot to index helper used by the grant logic.
package ysyx_23060236_axi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } arb_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // OR-reduction of set bit positions; exact for a one-hot (or zero) input.
  function automatic logic [2:0] onehot8_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = idx | 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ysyx_23060236_rr_pick.sv
// Round-robin picker: returns the one-hot of the first requester at or above ptr,
// wrapping past NM-1 back to 0.
module ysyx_23060236_rr_pick
  import ysyx_23060236_axi_pkg::*;
#(
  parameter int NM = 2,
  parameter int PW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] grant
);

  logic found_s;
  int   idx_s;

  // Scan NM positions starting at ptr; the first requester seen wins.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < NM; i++) begin
      idx_s = int'(ptr) + i;
      if (idx_s >= NM) begin
        idx_s = idx_s - NM;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[PW-1:0]]) begin
        grant[idx_s[PW-1:0]] = 1'b1;
        found_s              = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060236_axi_arbiter.sv
// NM-to-1 AXI4 arbiter: one outstanding transaction at a time, round-robin between
// masters, read before write within a master. Grant is held until the response completes.
module ysyx_23060236_axi_arbiter
  import ysyx_23060236_axi_pkg::*;
#(
  parameter int NM  = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic               clock,
  input  logic               reset,
  // upstream read address
  input  logic [NM-1:0]      m_arvalid,
  output logic [NM-1:0]      m_arready,
  input  logic [NM*AW-1:0]   m_araddr,
  input  logic [NM*8-1:0]    m_arlen,
  input  logic [NM*3-1:0]    m_arsize,
  input  logic [NM*2-1:0]    m_arburst,
  // upstream read data
  output logic [NM-1:0]      m_rvalid,
  input  logic [NM-1:0]      m_rready,
  output logic [DW-1:0]      m_rdata,
  output logic [1:0]         m_rresp,
  output logic               m_rlast,
  // upstream write address
  input  logic [NM-1:0]      m_awvalid,
  output logic [NM-1:0]      m_awready,
  input  logic [NM*AW-1:0]   m_awaddr,
  input  logic [NM*8-1:0]    m_awlen,
  input  logic [NM*3-1:0]    m_awsize,
  input  logic [NM*2-1:0]    m_awburst,
  // upstream write data
  input  logic [NM-1:0]      m_wvalid,
  output logic [NM-1:0]      m_wready,
  input  logic [NM*DW-1:0]   m_wdata,
  input  logic [NM*DW/8-1:0] m_wstrb,
  input  logic [NM-1:0]      m_wlast,
  // upstream write response
  output logic [NM-1:0]      m_bvalid,
  input  logic [NM-1:0]      m_bready,
  output logic [1:0]         m_bresp,
  // downstream master
  input  logic               io_master_arready,
  output logic               io_master_arvalid,
  output logic [AW-1:0]      io_master_araddr,
  output logic [IDW-1:0]     io_master_arid,
  output logic [7:0]         io_master_arlen,
  output logic [2:0]         io_master_arsize,
  output logic [1:0]         io_master_arburst,
  output logic               io_master_rready,
  input  logic               io_master_rvalid,
  input  logic [1:0]         io_master_rresp,
  input  logic [DW-1:0]      io_master_rdata,
  input  logic               io_master_rlast,
  input  logic [IDW-1:0]     io_master_rid,
  input  logic               io_master_awready,
  output logic               io_master_awvalid,
  output logic [AW-1:0]      io_master_awaddr,
  output logic [IDW-1:0]     io_master_awid,
  output logic [7:0]         io_master_awlen,
  output logic [2:0]         io_master_awsize,
  output logic [1:0]         io_master_awburst,
  input  logic               io_master_wready,
  output logic               io_master_wvalid,
  output logic [DW-1:0]      io_master_wdata,
  output logic [DW/8-1:0]    io_master_wstrb,
  output logic               io_master_wlast,
  output logic               io_master_bready,
  input  logic               io_master_bvalid,
  input  logic [1:0]         io_master_bresp,
  input  logic [IDW-1:0]     io_master_bid
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  arb_state_e    state_r;
  logic [PW-1:0] grant_r;
  logic [PW-1:0] rr_ptr_r;
  logic          aw_done_r;
  logic          w_done_r;

  logic [NM-1:0] req_s;
  logic [NM-1:0] pick_s;
  logic [PW-1:0] pick_idx_s;
  logic [PW-1:0] rr_next_s;
  logic          ar_hs_s;
  logic          r_last_hs_s;
  logic          aw_hs_s;
  logic          w_last_hs_s;
  logic          b_hs_s;
  logic          aw_done_s;
  logic          w_done_s;
  logic          unused_id_s;

  // Only one transaction is ever in flight, so response IDs carry no information.
  assign unused_id_s = ^{io_master_rid, io_master_bid};

  assign req_s = m_arvalid | m_awvalid;

  ysyx_23060236_rr_pick #(
    .NM (NM),
    .PW (PW)
  ) u_rr_pick (
    .req   (req_s),
    .ptr   (rr_ptr_r),
    .grant (pick_s)
  );

  assign pick_idx_s = PW'(onehot8_to_idx(8'(pick_s)));
  assign rr_next_s  = (grant_r == PW'(NM - 1)) ? '0 : grant_r + PW'(1);

  assign ar_hs_s     = io_master_arvalid & io_master_arready;
  assign r_last_hs_s = io_master_rvalid & io_master_rready & io_master_rlast;
  assign aw_hs_s     = io_master_awvalid & io_master_awready;
  assign w_last_hs_s = io_master_wvalid & io_master_wready & io_master_wlast;
  assign b_hs_s      = io_master_bvalid & io_master_bready;
  assign aw_done_s   = aw_done_r | aw_hs_s;
  assign w_done_s    = w_done_r | w_last_hs_s;

  // Broadcast response payloads; only the granted master sees a valid.
  assign m_rdata = io_master_rdata;
  assign m_rresp = io_master_rresp;
  assign m_rlast = io_master_rlast;
  assign m_bresp = io_master_bresp;

  // Payload and handshake routing between the granted master and the downstream port.
  always_comb begin
    io_master_araddr  = m_araddr[grant_r*AW +: AW];
    io_master_arlen   = m_arlen[grant_r*8 +: 8];
    io_master_arsize  = m_arsize[grant_r*3 +: 3];
    io_master_arburst = m_arburst[grant_r*2 +: 2];
    io_master_arid    = IDW'(grant_r);
    io_master_awaddr  = m_awaddr[grant_r*AW +: AW];
    io_master_awlen   = m_awlen[grant_r*8 +: 8];
    io_master_awsize  = m_awsize[grant_r*3 +: 3];
    io_master_awburst = m_awburst[grant_r*2 +: 2];
    io_master_awid    = IDW'(grant_r);
    io_master_wdata   = m_wdata[grant_r*DW +: DW];
    io_master_wstrb   = m_wstrb[grant_r*SW +: SW];
    io_master_wlast   = m_wlast[grant_r];
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;
    m_arready         = '0;
    m_rvalid          = '0;
    m_awready         = '0;
    m_wready          = '0;
    m_bvalid          = '0;
    case (state_r)
      RADDR: begin
        io_master_arvalid  = m_arvalid[grant_r];
        m_arready[grant_r] = io_master_arready;
      end
      RDATA: begin
        io_master_rready  = m_rready[grant_r];
        m_rvalid[grant_r] = io_master_rvalid;
      end
      WADDR: begin
        // Each channel is masked once its own handshake has completed.
        io_master_awvalid  = m_awvalid[grant_r] & ~aw_done_r;
        m_awready[grant_r] = io_master_awready & ~aw_done_r;
        io_master_wvalid   = m_wvalid[grant_r] & ~w_done_r;
        m_wready[grant_r]  = io_master_wready & ~w_done_r;
      end
      WRESP: begin
        io_master_bready  = m_bready[grant_r];
        m_bvalid[grant_r] = io_master_bvalid;
      end
      default: begin
        io_master_arvalid = 1'b0;
      end
    endcase
  end

  // Transaction FSM: grant latched in IDLE and held until the closing handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      rr_ptr_r  <= '0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_s) begin
            grant_r   <= pick_idx_s;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            if (m_arvalid[pick_idx_s]) begin
              state_r <= RADDR;
            end else begin
              state_r <= WADDR;
            end
          end
        end
        RADDR: begin
          if (ar_hs_s) begin
            state_r <= RDATA;
          end
        end
        RDATA: begin
          if (r_last_hs_s) begin
            state_r  <= IDLE;
            rr_ptr_r <= rr_next_s;
          end
        end
        WADDR: begin
          aw_done_r <= aw_done_s;
          w_done_r  <= w_done_s;
          if (aw_done_s && w_done_s) begin
            state_r <= WRESP;
          end
        end
        WRESP: begin
          if (b_hs_s) begin
            state_r  <= IDLE;
            rr_ptr_r <= rr_next_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_axi_arbiter.sv
// Directed bench for the AXI arbiter; the bench plays the downstream slave by hand.
module tb_ysyx_23060236_axi_arbiter;
  import ysyx_23060236_axi_pkg::*;

  localparam int NM  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 4;

  logic clock, reset;
  logic [NM-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM*AW-1:0] m_araddr, m_awaddr;
  logic [NM*8-1:0] m_arlen, m_awlen;
  logic [NM*3-1:0] m_arsize, m_awsize;
  logic [NM*2-1:0] m_arburst, m_awburst;
  logic [DW-1:0] m_rdata;
  logic [1:0] m_rresp, m_bresp;
  logic m_rlast;
  logic [NM-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*DW/8-1:0] m_wstrb;
  logic io_master_arready, io_master_arvalid, io_master_rready, io_master_rvalid, io_master_rlast;
  logic [AW-1:0] io_master_araddr, io_master_awaddr;
  logic [IDW-1:0] io_master_arid, io_master_awid, io_master_rid, io_master_bid;
  logic [7:0] io_master_arlen, io_master_awlen;
  logic [2:0] io_master_arsize, io_master_awsize;
  logic [1:0] io_master_arburst, io_master_awburst, io_master_rresp, io_master_bresp;
  logic [DW-1:0] io_master_rdata, io_master_wdata;
  logic io_master_awready, io_master_awvalid, io_master_wready, io_master_wvalid, io_master_wlast;
  logic [DW/8-1:0] io_master_wstrb;
  logic io_master_bready, io_master_bvalid;

  int checks, errors, beats;
  logic rv0_seen;
  logic [4:0] rr_pat;

  ysyx_23060236_axi_arbiter #(.NM(NM), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rready(io_master_rready), .io_master_rvalid(io_master_rvalid),
    .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wready(io_master_wready), .io_master_wvalid(io_master_wvalid),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic clr_inputs();
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_rready = '0;
    m_awvalid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
    io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rresp = 2'b00;
    io_master_rdata = '0; io_master_rlast = 1'b0; io_master_rid = '0;
    io_master_awready = 1'b0; io_master_wready = 1'b0;
    io_master_bvalid = 1'b0; io_master_bresp = 2'b00; io_master_bid = '0;
  endtask

  initial begin
    checks = 0; errors = 0; beats = 0; rv0_seen = 1'b0; rr_pat = 5'b11101;
    reset = 1'b0;
    clr_inputs();
    nxt(); nxt(); #1;
    chk_eq("rst_state", 64'(dut.state_r), 64'(IDLE));
    chk_eq("rst_grant", 64'(dut.grant_r), 64'd0);
    chk_eq("rst_arvalid", 64'(io_master_arvalid), 64'd0);
    chk_eq("rst_awvalid", 64'(io_master_awvalid), 64'd0);
    chk_eq("rst_m_arready", 64'(m_arready), 64'd0);
    nxt(); reset = 1'b1;

    // Both masters read in the same cycle: m0 first, then m1.
    nxt();
    m_arvalid = 2'b11; m_araddr = {32'h0000_2000, 32'h0000_1000};
    m_arsize = {3'd2, 3'd2}; m_arburst = {BURST_INCR, BURST_INCR}; #1;
    chk_eq("arb_latency", 64'(io_master_arvalid), 64'd0);
    nxt(); io_master_arready = 1'b1; #1;
    chk_eq("rd0_arvalid", 64'(io_master_arvalid), 64'd1);
    chk_eq("rd0_araddr", 64'(io_master_araddr), 64'h1000);
    chk_eq("rd0_arid", 64'(io_master_arid), 64'd0);
    chk_eq("rd0_arsize", 64'(io_master_arsize), 64'd2);
    chk_eq("rd0_arburst", 64'(io_master_arburst), 64'(BURST_INCR));
    chk_eq("rd0_m_arready", 64'(m_arready), 64'b01);
    nxt();
    m_arvalid = 2'b10; io_master_arready = 1'b0;
    io_master_rvalid = 1'b1; io_master_rlast = 1'b1; io_master_rdata = 32'h1111_1111;
    io_master_rresp = RESP_EXOKAY; m_rready = 2'b11; #1;
    chk_eq("rd0_m_rvalid", 64'(m_rvalid), 64'b01);
    chk_eq("rd0_rdata", 64'(m_rdata), 64'h1111_1111);
    chk_eq("rd0_rresp", 64'(m_rresp), 64'(RESP_EXOKAY));
    chk_eq("rd0_rlast", 64'(m_rlast), 64'd1);
    chk_eq("rd0_arvalid_off", 64'(io_master_arvalid), 64'd0);
    nxt(); io_master_rvalid = 1'b0; io_master_rlast = 1'b0; io_master_rresp = RESP_OKAY; #1;
    chk_eq("rd0_done_idle", 64'(dut.state_r), 64'(IDLE));
    nxt(); io_master_arready = 1'b1; #1;
    chk_eq("rd1_arid", 64'(io_master_arid), 64'd1);
    chk_eq("rd1_araddr", 64'(io_master_araddr), 64'h2000);
    chk_eq("rd1_m_arready", 64'(m_arready), 64'b10);
    nxt();
    m_arvalid = 2'b00; io_master_arready = 1'b0;
    io_master_rvalid = 1'b1; io_master_rlast = 1'b1; io_master_rdata = 32'h2222_2222; #1;
    chk_eq("rd1_m_rvalid", 64'(m_rvalid), 64'b10);
    nxt(); io_master_rvalid = 1'b0; io_master_rlast = 1'b0; m_rready = 2'b00;

    // m1 4-beat read with rready pattern 1,0,1,1,1.
    m_arvalid = 2'b10; m_arlen = {8'd3, 8'd0}; m_araddr[32 +: 32] = 32'h0000_3000;
    nxt(); io_master_arready = 1'b1; #1;
    chk_eq("r4_arlen", 64'(io_master_arlen), 64'd3);
    nxt(); m_arvalid = 2'b00; io_master_arready = 1'b0; io_master_rvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nxt();
      m_rready = {rr_pat[k], 1'b0};
      io_master_rlast = (beats == 3);
      io_master_rdata = 32'h0000_00A0 + 32'(beats);
      #1;
      chk_eq("r4_rready", 64'(io_master_rready), 64'(rr_pat[k]));
      if (m_rvalid[0]) rv0_seen = 1'b1;
      if (m_rvalid[1] && m_rready[1]) begin
        chk_eq("r4_rdata", 64'(m_rdata), 64'h0A0 + 64'(beats));
        beats++;
      end
    end
    nxt(); io_master_rvalid = 1'b0; io_master_rlast = 1'b0; m_rready = 2'b00; #1;
    chk_eq("r4_beats", 64'(beats), 64'd4);
    chk_eq("r4_m0_quiet", 64'(rv0_seen), 64'd0);
    chk_eq("r4_idle", 64'(dut.state_r), 64'(IDLE));

    // m0 write: W completes two cycles before AW.
    m_awvalid = 2'b01; m_awaddr[0 +: 32] = 32'h0000_4000; m_awsize = {3'd2, 3'd2};
    m_awburst = {BURST_INCR, BURST_INCR}; m_awlen = '0;
    m_wvalid = 2'b01; m_wdata[0 +: 32] = 32'hDEAD_BEEF; m_wstrb[0 +: 4] = 4'hF; m_wlast = 2'b01;
    nxt(); io_master_wready = 1'b1; #1;
    chk_eq("wr_state", 64'(dut.state_r), 64'(WADDR));
    chk_eq("wr_wvalid", 64'(io_master_wvalid), 64'd1);
    chk_eq("wr_wdata", 64'(io_master_wdata), 64'hDEAD_BEEF);
    chk_eq("wr_wstrb", 64'(io_master_wstrb), 64'hF);
    chk_eq("wr_wlast", 64'(io_master_wlast), 64'd1);
    chk_eq("wr_m_wready", 64'(m_wready), 64'b01);
    chk_eq("wr_awvalid", 64'(io_master_awvalid), 64'd1);
    chk_eq("wr_awaddr", 64'(io_master_awaddr), 64'h4000);
    chk_eq("wr_awid", 64'(io_master_awid), 64'd0);
    chk_eq("wr_awlen", 64'(io_master_awlen), 64'd0);
    chk_eq("wr_awsize", 64'(io_master_awsize), 64'd2);
    chk_eq("wr_awburst", 64'(io_master_awburst), 64'(BURST_INCR));
    nxt(); io_master_wready = 1'b0; m_wvalid = 2'b00; #1;
    chk_eq("wr_wvalid_off", 64'(io_master_wvalid), 64'd0);
    nxt(); #1;
    chk_eq("wr_wait_aw", 64'(dut.state_r), 64'(WADDR));
    io_master_awready = 1'b1; #1;
    chk_eq("wr_m_awready", 64'(m_awready), 64'b01);
    nxt();
    io_master_awready = 1'b0; m_awvalid = 2'b00;
    io_master_bvalid = 1'b1; io_master_bresp = RESP_OKAY; m_bready = 2'b11; #1;
    chk_eq("wr_wresp", 64'(dut.state_r), 64'(WRESP));
    chk_eq("wr_m_bvalid", 64'(m_bvalid), 64'b01);
    chk_eq("wr_bresp", 64'(m_bresp), 64'(RESP_OKAY));
    chk_eq("wr_bready", 64'(io_master_bready), 64'd1);
    nxt(); io_master_bvalid = 1'b0; m_bready = 2'b00; #1;
    chk_eq("wr_idle", 64'(dut.state_r), 64'(IDLE));

    // m0 read+write; m1 joins mid-read and is served before m0's write.
    m_arvalid = 2'b01; m_awvalid = 2'b01; m_arlen = '0;
    m_araddr[0 +: 32] = 32'h0000_5000; m_awaddr[0 +: 32] = 32'h0000_6000;
    nxt(); io_master_arready = 1'b1; m_arvalid = 2'b11; m_araddr[32 +: 32] = 32'h0000_7000; #1;
    chk_eq("mix_rd_first", 64'(dut.state_r), 64'(RADDR));
    chk_eq("mix_m0_araddr", 64'(io_master_araddr), 64'h5000);
    chk_eq("mix_no_aw", 64'(io_master_awvalid), 64'd0);
    nxt();
    io_master_arready = 1'b0; m_arvalid = 2'b10;
    io_master_rvalid = 1'b1; io_master_rlast = 1'b1; m_rready = 2'b01; #1;
    chk_eq("mix_m0_rvalid", 64'(m_rvalid), 64'b01);
    nxt(); io_master_rvalid = 1'b0; io_master_rlast = 1'b0; m_rready = 2'b00;
    nxt(); io_master_arready = 1'b1; #1;
    chk_eq("mix_m1_arid", 64'(io_master_arid), 64'd1);
    chk_eq("mix_m1_araddr", 64'(io_master_araddr), 64'h7000);
    nxt();
    io_master_arready = 1'b0; m_arvalid = 2'b00;
    io_master_rvalid = 1'b1; io_master_rlast = 1'b1; m_rready = 2'b10; #1;
    chk_eq("mix_m1_rvalid", 64'(m_rvalid), 64'b10);
    nxt(); io_master_rvalid = 1'b0; io_master_rlast = 1'b0; m_rready = 2'b00;
    nxt();
    m_wvalid = 2'b01; m_wlast = 2'b01; m_wdata[0 +: 32] = 32'h1234_5678;
    io_master_wready = 1'b1; io_master_awready = 1'b1; #1;
    chk_eq("mix_wr_state", 64'(dut.state_r), 64'(WADDR));
    chk_eq("mix_awaddr", 64'(io_master_awaddr), 64'h6000);
    chk_eq("mix_awid", 64'(io_master_awid), 64'd0);
    nxt();
    io_master_wready = 1'b0; io_master_awready = 1'b0; m_awvalid = 2'b00; m_wvalid = 2'b00;
    io_master_bvalid = 1'b1; io_master_bresp = RESP_SLVERR; m_bready = 2'b01; #1;
    chk_eq("mix_same_cycle", 64'(dut.state_r), 64'(WRESP));
    chk_eq("mix_bresp", 64'(m_bresp), 64'(RESP_SLVERR));
    chk_eq("mix_m_bvalid", 64'(m_bvalid), 64'b01);
    nxt(); io_master_bvalid = 1'b0; io_master_bresp = RESP_OKAY; m_bready = 2'b00;

    // Reset during beat 2 of a 4-beat m1 read, then a clean m1 read.
    m_arvalid = 2'b10; m_arlen = {8'd3, 8'd0}; m_araddr[32 +: 32] = 32'h0000_8000;
    nxt(); io_master_arready = 1'b1;
    nxt();
    io_master_arready = 1'b0; m_arvalid = 2'b00;
    io_master_rvalid = 1'b1; io_master_rlast = 1'b0; m_rready = 2'b10;
    nxt(); #1;
    chk_eq("rst_mid_pre", 64'(m_rvalid), 64'b10);
    reset = 1'b0; #1;
    chk_eq("rst_mid_rvalid", 64'(m_rvalid), 64'd0);
    chk_eq("rst_mid_rready", 64'(io_master_rready), 64'd0);
    chk_eq("rst_mid_state", 64'(dut.state_r), 64'(IDLE));
    chk_eq("rst_mid_rrptr", 64'(dut.rr_ptr_r), 64'd0);
    chk_eq("rst_mid_arvalid", 64'(io_master_arvalid), 64'd0);
    nxt(); clr_inputs();
    nxt(); reset = 1'b1;
    m_arvalid = 2'b10; m_araddr[32 +: 32] = 32'h0000_9000;
    nxt(); io_master_arready = 1'b1; #1;
    chk_eq("post_rst_raddr", 64'(dut.state_r), 64'(RADDR));
    chk_eq("post_rst_arid", 64'(io_master_arid), 64'd1);
    chk_eq("post_rst_araddr", 64'(io_master_araddr), 64'h9000);
    nxt();
    io_master_arready = 1'b0; m_arvalid = 2'b00;
    io_master_rvalid = 1'b1; io_master_rlast = 1'b1; io_master_rdata = 32'h5555_5555; m_rready = 2'b10; #1;
    chk_eq("post_rst_rvalid", 64'(m_rvalid), 64'b10);
    chk_eq("post_rst_rdata", 64'(m_rdata), 64'h5555_5555);
    nxt(); io_master_rvalid = 1'b0; io_master_rlast = 1'b0; m_rready = 2'b00; #1;
    chk_eq("post_rst_idle", 64'(dut.state_r), 64'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_axi_arbiter.md
YSYX_23060236_AXI_ARBITER -- requirements
Module: ysyx_23060236_axi_arbiter

Interface
REQ-001 SHALL take parameter NM, default 2: number of upstream AXI4 masters (2..8).
REQ-002 SHALL take parameter AW, default 32: address width.
REQ-003 SHALL take parameter DW, default 32: data width.
REQ-004 SHALL take parameter IDW, default 4: downstream ID width, with IDW >= clog2(NM).
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have upstream AR ports m_arvalid (in, NM), m_arready (out, NM), m_araddr (in, NM*AW), m_arlen (in, NM*8), m_arsize (in, NM*3), m_arburst (in, NM*2), packed with master i at slice i.
REQ-008 SHALL have upstream R ports m_rvalid (out, NM), m_rready (in, NM), m_rdata (out, DW), m_rresp (out, 2), m_rlast (out, 1); rdata, rresp and rlast are broadcast to all masters.
REQ-009 SHALL have upstream AW ports m_awvalid, m_awready, m_awaddr, m_awlen, m_awsize, m_awburst, packed as in REQ-007.
REQ-010 SHALL have upstream W ports m_wvalid (in, NM), m_wready (out, NM), m_wdata (in, NM*DW), m_wstrb (in, NM*DW/8), m_wlast (in, NM).
REQ-011 SHALL have upstream B ports m_bvalid (out, NM), m_bready (in, NM), m_bresp (out, 2, broadcast).
REQ-012 SHALL have one downstream AXI4 master port io_master_* carrying all AR/R/AW/W/B signals including arid/awid/rid/bid of width IDW.

Function
REQ-013 SHALL use states IDLE, RADDR, RDATA, WADDR, WRESP.
REQ-014 SHALL treat master i as requesting when m_arvalid[i] | m_awvalid[i] is high.
REQ-015 SHALL, in IDLE with any request, register a grant chosen round-robin from rr_ptr (first requester at or above rr_ptr, wrapping past NM-1 to 0) and move to RADDR if the winner's arvalid is high, otherwise to WADDR; read has priority within one master.
REQ-016 SHALL give a 1-cycle arbitration latency: downstream valid is first asserted the cycle after the request is seen in IDLE.
REQ-017 SHALL, in RADDR, forward the granted AR fields to io_master_ar*, drive arid = grant index zero-extended, pass arready back only to the granted master, and move to RDATA on arvalid & arready.
REQ-018 SHALL, in RDATA, route io_master_rvalid to m_rvalid[grant] only and io_master_rready from m_rready[grant], and return to IDLE on rvalid & rready & rlast.
REQ-019 SHALL, in WADDR, present AW and W of the granted master concurrently, track aw_done and w_done independently (w_done set on the wvalid & wready & wlast beat), and move to WRESP once both are set, in either order or in the same cycle.
REQ-020 SHALL, in WRESP, route B to the granted master and return to IDLE on bvalid & bready.
REQ-021 SHALL set rr_ptr to (grant+1) mod NM when returning to IDLE.
REQ-022 SHALL hold every valid and ready to non-granted masters at 0, and all downstream valid/ready at 0 in IDLE.
REQ-023 SHALL ignore the values of rid and bid; a single transaction is outstanding at any time.
REQ-024 SHALL leave downstream valid outputs independent of same-cycle downstream ready.
REQ-025 SHALL hold the grant until the transaction completes, so an upstream request that drops mid-transaction does not release the grant.

Reset
REQ-026 SHALL, on reset low, immediately set state to IDLE, grant to 0, rr_ptr to 0, aw_done and w_done to 0, and drive all valid/ready outputs to 0, including mid-burst.
REQ-027 SHALL release reset synchronously to clock and accept requests from the first clock edge after release.

Structure
REQ-028 SHALL place the state enum and the AXI burst/resp constants in a shared package, ysyx_23060236_axi_pkg.
REQ-029 SHALL implement the round-robin picker (request vector and pointer in, one-hot grant out) as sub-module ysyx_23060236_rr_pick; the datapath muxes stay in the top module.

Verification
REQ-030 SHALL cover the case where m0 and m1 both assert arvalid in the same cycle after reset: m0 is granted first with arid=0; m1 is granted after m0's rlast with arid=1.
REQ-031 SHALL cover an m1 read with arlen=3 and rready toggling 1,0,1,1,1: exactly 4 beats reach m1, m_rvalid[0] stays 0, and the FSM is in IDLE the cycle after the last beat.
REQ-032 SHALL cover an m0 write where W (wlast=1, wstrb=0xF, wdata=0xDEADBEEF) completes 2 cycles before AW: WRESP is entered only after awready, and bresp=2'b00 reaches m0 only.
REQ-033 SHALL cover m0 asserting both arvalid and awvalid: the read completes first, then m1 is granted (if requesting) before m0's write per rr_ptr.
REQ-034 SHALL cover reset asserted during beat 2 of a 4-beat read: all valids drop asynchronously, state is IDLE, and a new m1 read after release completes normally.
